prog_mod_counter: RTL and testbench
===================================

// Module: prog_mod_counter
// PURPOSE
//  Runtime-programmable modulus counter: up/down, enable, sync clear, parallel load.
//  Three modes: wrap, saturate, one-shot (FSM-sequenced).
//  Generalised timebase/divider for tick generators, baud dividers and FSM timers;
//  replaces fixed compile-time mod-M counters.
// PARAMETERS
//  W          8   counter and modulus register width (bits)
//  M_DEFAULT  10  modulus loaded at reset; legal range 2..2^W-1
// PORTS
//  clk      in   1    clock, rising edge
//  reset    in   1    asynchronous, active-high reset
//  en       in   1    count enable; one count event per cycle while high
//  clr      in   1    synchronous clear
//  ld       in   1    synchronous parallel load of ld_val
//  ld_val   in   W    load value
//  m_wr     in   1    write new modulus
//  m_val    in   W    new modulus value
//  up_dn    in   1    1 = count up, 0 = count down
//  mode     in   2    00 wrap, 01 one-shot, 10 saturate, 11 treated as wrap
//  start    in   1    one-shot trigger (ignored in other modes)
//  q        out  W    current count (registered)
//  m_cur    out  W    active modulus (registered)
//  tc       out  1    terminal count, combinational
//  busy     out  1    one-shot in RUN state
//  done     out  1    registered 1-cycle pulse when one-shot completes
// BEHAVIOUR
//  Reset state
//   - q=0, m_cur=M_DEFAULT, state=IDLE, done=0, busy=0.
//  Terminal value T
//   - T = m_cur-1 when up_dn=1; T = 0 when up_dn=0.
//   - tc = (q==T); independent of en.
//  Modulus write
//   - m_wr: m_cur <= max(m_val,2) next cycle; m_val<2 clamps to 2.
//   - A count in the same cycle uses the old m_cur.
//  Priority per cycle: clr > ld > count.
//   - clr: q<=0, state<=IDLE, done<=0.
//   - ld: q <= (ld_val>=m_cur) ? m_cur-1 : ld_val. State is unchanged.
//  Count event (en=1, no clr/ld, mode permits)
//   - Up: q<=q+1, or 0 if q>=T.
//   - Down: q<=q-1, or m_cur-1 if q==0.
//   - Out-of-range q (q>=m_cur after a modulus shrink) at a count event: up -> 0, down -> m_cur-1.
//  Wrap mode: counts on every en; wraps at T.
//  Saturate mode: counts toward T, then holds q=T while en stays high.
//   - Reversing up_dn leaves saturation.
//  One-shot FSM (mode=01)
//   - IDLE: q holds, no counting.
//     start=1 -> q <= (up_dn ? 0 : m_cur-1), go RUN.
//   - RUN: busy=1; counts on en. A count event with q==T -> q holds T, go DONE.
//   - DONE: done=1 for exactly one cycle, then IDLE. q holds T.
//   - start in RUN/DONE is ignored. start and clr together: clr wins.
//   - Leaving mode 01 at any time forces IDLE and done=0.
//  Latency
//   - q, m_cur, done update 1 cycle after the qualifying input edge; tc follows q combinationally.
//  Arithmetic: all compares unsigned W-bit; q never exceeds m_cur-1 except transiently after a modulus shrink.
//  Reset mid-operation: async; all registers return to reset state immediately, regardless of mode.
// TESTING
//  T1 wrap up
//   - reset, mode=00, up_dn=1, en=1 for 25 cycles.
//   - q=0..9,0..9,0..4; tc high at q=9 (cycles 10, 20).
//  T2 down + modulus write
//   - m_wr m_val=5, then up_dn=0, en=1.
//   - q=...0,4,3,2,1,0,4.
//   - m_val=1 -> m_cur=2.
//  T3 saturate
//   - mode=10, m=6, up, en=1 for 10 cycles.
//   - q=0..5, then holds 5 with tc=1.
//   - up_dn=0 -> q=4.
//  T4 one-shot
//   - mode=01, m=4, up, en=1, start pulse.
//   - busy 1 cycle after start; q=0,1,2,3.
//   - done pulse 1 cycle after q reaches 3; busy falls; q stays 3.
//  T5 priority + clamp
//   - clr, ld, en together -> q=0.
//   - ld with ld_val=12, m=10 -> q=9.
//   - shrink m 10->4 at q=7, next up count -> q=0.
//  T6 async reset mid-RUN
//   - assert reset between clock edges in one-shot RUN.
//   - q=0, m_cur=10, busy=0, done=0 immediately.

Source files
------------

// File: rtl/prog_mod_counter_if.sv
// Control and status bundle for prog_mod_counter: master drives controls,
// slave (the counter) drives count, modulus and status.
interface prog_mod_counter_if #(
  parameter int W = 8
);
  logic         en;
  logic         clr;
  logic         ld;
  logic [W-1:0] ld_val;
  logic         m_wr;
  logic [W-1:0] m_val;
  logic         up_dn;
  logic [1:0]   mode;
  logic         start;
  logic [W-1:0] q;
  logic [W-1:0] m_cur;
  logic         tc;
  logic         busy;
  logic         done;

  modport master (
    output en, clr, ld, ld_val, m_wr, m_val, up_dn, mode, start,
    input  q, m_cur, tc, busy, done
  );

  modport slave (
    input  en, clr, ld, ld_val, m_wr, m_val, up_dn, mode, start,
    output q, m_cur, tc, busy, done
  );
endinterface

// File: rtl/prog_mod_counter.sv
// Runtime-programmable modulus counter with wrap, saturate and one-shot modes.
// Priority per cycle is clr > ld > count/start; modulus writes are independent.
module prog_mod_counter #(
  parameter int W         = 8,
  parameter int M_DEFAULT = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  prog_mod_counter_if.slave     bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [W-1:0] M_RST = W'(M_DEFAULT);
  localparam logic [1:0]   MODE_ONESHOT = 2'b01;
  localparam logic [1:0]   MODE_SAT     = 2'b10;

  state_t       state, state_nxt;
  logic [W-1:0] q_r, q_nxt;
  logic [W-1:0] m_r;
  logic [W-1:0] m_last;
  logic [W-1:0] term;
  logic [W-1:0] q_adv;
  logic [W-1:0] ld_clamp;
  logic         at_term;

  assign m_last   = m_r - W'(1);
  assign term     = bus.up_dn ? m_last : '0;
  assign at_term  = (q_r == term);
  assign ld_clamp = (bus.ld_val >= m_r) ? m_last : bus.ld_val;

  // Out-of-range q (after a modulus shrink) snaps to the wrap target.
  always_comb begin
    q_adv = '0;
    if (bus.up_dn)
      q_adv = (q_r >= m_last) ? '0 : q_r + W'(1);
    else
      q_adv = ((q_r == '0) || (q_r >= m_r)) ? m_last : q_r - W'(1);
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q_r;
    if (bus.clr) begin
      q_nxt     = '0;
      state_nxt = IDLE;
    end else if (bus.ld) begin
      q_nxt = ld_clamp;
      // DONE is a single-cycle state even while loading.
      if (state == DONE) state_nxt = IDLE;
    end else begin
      case (bus.mode)
        MODE_ONESHOT: begin
          case (state)
            IDLE: if (bus.start) begin
              q_nxt     = bus.up_dn ? '0 : m_last;
              state_nxt = RUN;
            end
            RUN: if (bus.en) begin
              if (at_term) state_nxt = DONE;
              else         q_nxt     = q_adv;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
          endcase
        end
        MODE_SAT: if (bus.en && !at_term) q_nxt = q_adv;
        default:  if (bus.en) q_nxt = q_adv;
      endcase
    end
    if (bus.mode != MODE_ONESHOT) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      q_r   <= '0;
      m_r   <= M_RST;
    end else begin
      state <= state_nxt;
      q_r   <= q_nxt;
      if (bus.m_wr) m_r <= (bus.m_val < W'(2)) ? W'(2) : bus.m_val;
    end
  end

  assign bus.q     = q_r;
  assign bus.m_cur = m_r;
  assign bus.tc    = at_term;
  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);
endmodule

// File: tb/tb_prog_mod_counter.sv
// Directed and randomized checks of prog_mod_counter against a cycle-level
// arithmetic reference model.
module tb_prog_mod_counter;
  localparam int W = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  // reference model state
  int mq, mm;
  bit mrun, mfin;

  prog_mod_counter_if #(.W(W)) bus ();

  prog_mod_counter #(.W(W), .M_DEFAULT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    bus.en = 0; bus.clr = 0; bus.ld = 0; bus.ld_val = '0;
    bus.m_wr = 0; bus.m_val = '0; bus.start = 0;
  endtask

  task automatic model_reset();
    mq = 0; mm = 10; mrun = 0; mfin = 0;
  endtask

  function automatic int advance(int q, int m, bit up);
    if (q >= m) return up ? 0 : m - 1;
    return up ? (q + 1) % m : (q + m - 1) % m;
  endfunction

  task automatic model_step();
    int  nq, nm, t;
    bit  nrun, nfin;
    t    = bus.up_dn ? mm - 1 : 0;
    nq   = mq; nm = mm; nrun = mrun; nfin = 0;
    if (bus.m_wr) nm = (int'(bus.m_val) < 2) ? 2 : int'(bus.m_val);
    if (bus.clr) begin
      nq = 0; nrun = 0;
    end else if (bus.ld) begin
      nq = (int'(bus.ld_val) >= mm) ? mm - 1 : int'(bus.ld_val);
    end else if (bus.mode == 2'b01) begin
      if (mfin) nrun = 0;
      else if (mrun) begin
        if (bus.en) begin
          if (mq == t) begin nrun = 0; nfin = 1; end
          else nq = advance(mq, mm, bus.up_dn);
        end
      end else if (bus.start) begin
        nq = bus.up_dn ? 0 : mm - 1;
        nrun = 1;
      end
    end else if (bus.mode == 2'b10) begin
      if (bus.en && mq != t) nq = advance(mq, mm, bus.up_dn);
    end else if (bus.en) begin
      nq = advance(mq, mm, bus.up_dn);
    end
    if (bus.mode != 2'b01) begin nrun = 0; nfin = 0; end
    mq = nq; mm = nm; mrun = nrun; mfin = nfin;
  endtask

  task automatic check_model(input string tag);
    int t;
    t = bus.up_dn ? mm - 1 : 0;
    chk({tag, "_q"},    bus.q,     mq);
    chk({tag, "_m"},    bus.m_cur, mm);
    chk({tag, "_busy"}, bus.busy,  mrun);
    chk({tag, "_done"}, bus.done,  mfin);
    chk({tag, "_tc"},   bus.tc,    (mq == t));
  endtask

  // One clock: model consumes the inputs present at the edge, DUT sampled 1ns later.
  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  initial begin
    int exp_q[$];
    reset = 1'b1;
    idle_in();
    bus.up_dn = 1; bus.mode = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", bus.q, 0);
    chk("rst_m", bus.m_cur, 10);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    reset = 1'b0;

    // T1 wrap up
    bus.en = 1;
    for (int i = 1; i <= 24; i++) begin
      cycle("t1");
      chk("t1_seq", bus.q, i % 10);
      if (i % 10 == 9) chk("t1_tc", bus.tc, 1);
    end

    // T2 modulus 5, count down
    bus.en = 0; bus.m_wr = 1; bus.m_val = 5;
    cycle("t2_mwr");
    chk("t2_m5", bus.m_cur, 5);
    bus.m_wr = 0; bus.up_dn = 0; bus.en = 1;
    exp_q = '{3, 2, 1, 0, 4, 3};
    foreach (exp_q[i]) begin
      cycle("t2");
      chk("t2_seq", bus.q, exp_q[i]);
    end
    bus.en = 0; bus.m_wr = 1; bus.m_val = 1;
    cycle("t2_clamp");
    chk("t2_m_clamp", bus.m_cur, 2);

    // T3 saturate
    bus.mode = 2'b10; bus.m_val = 6; bus.clr = 1;
    cycle("t3_setup");
    bus.m_wr = 0; bus.clr = 0; bus.up_dn = 1; bus.en = 1;
    for (int i = 1; i <= 10; i++) begin
      cycle("t3");
      chk("t3_seq", bus.q, (i < 5) ? i : 5);
    end
    chk("t3_tc_hold", bus.tc, 1);
    bus.up_dn = 0;
    cycle("t3_rev");
    chk("t3_rev_q", bus.q, 4);

    // T4 one-shot
    bus.mode = 2'b01; bus.clr = 1; bus.m_wr = 1; bus.m_val = 4; bus.en = 0; bus.up_dn = 1;
    cycle("t4_setup");
    bus.clr = 0; bus.m_wr = 0; bus.en = 1; bus.start = 1;
    cycle("t4_start");
    chk("t4_busy", bus.busy, 1);
    chk("t4_q0", bus.q, 0);
    bus.start = 0;
    for (int i = 1; i <= 3; i++) begin
      cycle("t4");
      chk("t4_seq", bus.q, i);
    end
    cycle("t4_fin");
    chk("t4_done", bus.done, 1);
    chk("t4_busy_fall", bus.busy, 0);
    chk("t4_q_hold", bus.q, 3);
    cycle("t4_after");
    chk("t4_done_pulse", bus.done, 0);

    // T5 priority and clamping
    bus.mode = 2'b00; bus.en = 0; bus.m_wr = 1; bus.m_val = 10;
    cycle("t5_setup");
    bus.m_wr = 0; bus.clr = 1; bus.ld = 1; bus.ld_val = 7; bus.en = 1;
    cycle("t5_pri");
    chk("t5_clr_wins", bus.q, 0);
    bus.clr = 0; bus.ld_val = 12;
    cycle("t5_ld");
    chk("t5_ld_clamp", bus.q, 9);
    bus.ld_val = 7;
    cycle("t5_ld7");
    bus.ld = 0; bus.en = 0; bus.m_wr = 1; bus.m_val = 4;
    cycle("t5_shrink");
    chk("t5_q_oor", bus.q, 7);
    bus.m_wr = 0; bus.en = 1;
    cycle("t5_oor");
    chk("t5_oor_wrap", bus.q, 0);

    // T6 async reset in RUN
    bus.mode = 2'b01; bus.start = 1;
    cycle("t6_start");
    bus.start = 0;
    cycle("t6_run");
    chk("t6_running", bus.busy, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t6_q", bus.q, 0);
    chk("t6_m", bus.m_cur, 10);
    chk("t6_busy", bus.busy, 0);
    chk("t6_done", bus.done, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle_in();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus.en     = ($urandom_range(0, 3) != 0);
      bus.clr    = ($urandom_range(0, 40) == 0);
      bus.ld     = ($urandom_range(0, 20) == 0);
      bus.ld_val = W'($urandom_range(0, 15));
      bus.m_wr   = ($urandom_range(0, 30) == 0);
      bus.m_val  = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 255))
                                                : W'($urandom_range(0, 12));
      bus.start  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) bus.up_dn = ~bus.up_dn;
      if ($urandom_range(0, 40) == 0) bus.mode = 2'($urandom_range(0, 3));
      cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
